// File: rtl/video_to_axis_packer_pkg.sv
// ============================================================================
// SystemPkg: shared FSM state and FIFO entry types for video_to_axis_packer
// Rev 1.0
// ============================================================================
`default_nettype none

package SystemPkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_DE = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DROP    = 2'd3
  } pack_state_e;

  // A FIFO entry is {entry_flags_t, pixel}; the pixel width follows DSIZE at the use site.
  typedef struct packed {
    logic sof;
    logic eol;
  } entry_flags_t;

endpackage

`default_nettype wire

// File: rtl/vid_sync_fifo.sv
// ============================================================================
// vid_sync_fifo: single-clock show-ahead FIFO, full/empty from registered pointers
// Rev 1.0
// ============================================================================
`default_nettype none

module vid_sync_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] c_ptr_one = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Full is judged on pointer state only, so a push into a full FIFO is refused
  // even when a pop happens in the same cycle.
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_dout  = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
    if (do_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_din;
  end

endmodule

`default_nettype wire

// File: rtl/video_to_axis_packer.sv
// ============================================================================
// video_to_axis_packer: packs vs/hs/de pixel timing into an AXI4-Stream video feed
// Rev 1.0
// ============================================================================
`default_nettype none

module video_to_axis_packer
  import SystemPkg::*;
#(
  parameter int unsigned DSIZE      = 24,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic             enable,
  input  logic [15:0]      hactive,
  input  logic [15:0]      vactive,
  input  logic             vs,
  input  logic             hs,
  input  logic             de,
  input  logic [DSIZE-1:0] data,
  output logic [DSIZE-1:0] m_tdata,
  output logic             m_tvalid,
  output logic             m_tuser,
  output logic             m_tlast,
  input  logic             m_tready,
  input  logic             clear_err,
  output logic             overflow,
  output logic             line_err,
  output logic             frame_err
);

  // Input register stage
  logic             vs_q, vs_d, vs_rise_q, vs_rise_d, de_q, de_d;
  logic [DSIZE-1:0] data_q, data_d;
  logic             en_q, en_d;
  logic [15:0]      hact_q, hact_d, vact_q, vact_d;

  // Packing FSM and counters
  pack_state_e      state_q, state_d;
  logic [15:0]      pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic             after_eol_q, after_eol_d;
  logic             overflow_q, overflow_d, line_err_q, line_err_d, frame_err_q, frame_err_d;
  logic             ovf_set, line_set, frame_set;
  logic             last_pix, last_line;

  // FIFO interface
  entry_flags_t     wr_flags, rd_flags;
  logic [DSIZE+1:0] wr_entry, rd_entry;
  logic             push, pop, fifo_full, fifo_empty;

  always_comb begin
    vs_d      = vs;
    vs_rise_d = vs & ~vs_q;
    // A pixel coinciding with hsync is malformed timing and is treated as blanking.
    de_d      = de & ~hs;
    data_d    = data;
    en_d      = en_q;
    hact_d    = hact_q;
    vact_d    = vact_q;
    if (vs_rise_d) begin
      en_d   = enable;
      hact_d = hactive;
      vact_d = vactive;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      vs_q      <= 1'b0;
      vs_rise_q <= 1'b0;
      de_q      <= 1'b0;
      data_q    <= '0;
      en_q      <= 1'b0;
      hact_q    <= '0;
      vact_q    <= '0;
    end else begin
      vs_q      <= vs_d;
      vs_rise_q <= vs_rise_d;
      de_q      <= de_d;
      data_q    <= data_d;
      en_q      <= en_d;
      hact_q    <= hact_d;
      vact_q    <= vact_d;
    end
  end

  assign last_pix  = (pix_cnt_q == hact_q - 16'd1);
  assign last_line = (line_cnt_q == vact_q - 16'd1);

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    after_eol_d = after_eol_q;
    wr_flags    = '0;
    push        = 1'b0;
    ovf_set     = 1'b0;
    line_set    = 1'b0;
    frame_set   = 1'b0;
    if (vs_rise_q) begin
      pix_cnt_d   = '0;
      line_cnt_d  = '0;
      after_eol_d = 1'b0;
      frame_set   = (state_q == ST_ACTIVE);
      state_d     = (en_q && hact_q != 16'd0 && vact_q != 16'd0) ? ST_WAIT_DE : ST_IDLE;
    end else if (state_q == ST_WAIT_DE || state_q == ST_ACTIVE) begin
      if (!de_q) begin
        after_eol_d = 1'b0;
        if (pix_cnt_q != 16'd0) begin
          line_set  = 1'b1;
          pix_cnt_d = '0;
        end
      end else if (after_eol_q) begin
        line_set = 1'b1;
      end else if (fifo_full) begin
        ovf_set = 1'b1;
        state_d = ST_DROP;
      end else begin
        push         = 1'b1;
        wr_flags.sof = (state_q == ST_WAIT_DE);
        wr_flags.eol = last_pix;
        state_d      = ST_ACTIVE;
        if (last_pix) begin
          pix_cnt_d   = '0;
          line_cnt_d  = line_cnt_q + 16'd1;
          after_eol_d = 1'b1;
          if (last_line) state_d = ST_IDLE;
        end else begin
          pix_cnt_d = pix_cnt_q + 16'd1;
        end
      end
    end
  end

  // Sticky flags: a set in the same cycle as clear_err wins.
  always_comb begin
    overflow_d  = (overflow_q  & ~clear_err) | ovf_set;
    line_err_d  = (line_err_q  & ~clear_err) | line_set;
    frame_err_d = (frame_err_q & ~clear_err) | frame_set;
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= ST_IDLE;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      after_eol_q <= 1'b0;
      overflow_q  <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      after_eol_q <= after_eol_d;
      overflow_q  <= overflow_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign wr_entry = {wr_flags, data_q};
  assign pop      = m_tvalid & m_tready;

  vid_sync_fifo #(
    .WIDTH (DSIZE + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (pclk),
    .rst     (prst),
    .i_push  (push),
    .i_din   (wr_entry),
    .i_pop   (pop),
    .o_dout  (rd_entry),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign rd_flags  = rd_entry[DSIZE+1:DSIZE];
  assign m_tvalid  = ~fifo_empty;
  assign m_tuser   = rd_flags.sof;
  assign m_tlast   = rd_flags.eol;
  assign m_tdata   = rd_entry[DSIZE-1:0];
  assign overflow  = overflow_q;
  assign line_err  = line_err_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_video_to_axis_packer.sv
// ============================================================================
// tb_video_to_axis_packer: directed self-checking bench for video_to_axis_packer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_video_to_axis_packer;
  import SystemPkg::*;

  localparam int unsigned DSIZE      = 24;
  localparam int unsigned FIFO_DEPTH = 16;

  logic             pclk = 1'b0;
  logic             prst, enable, vs, hs, de, m_tready, clear_err;
  logic [15:0]      hactive, vactive;
  logic [DSIZE-1:0] data, m_tdata;
  logic             m_tvalid, m_tuser, m_tlast;
  logic             overflow, line_err, frame_err;

  int               n_checks = 0;
  int               n_pass   = 0;
  logic [DSIZE+1:0] beats[$];

  always #5 pclk = ~pclk;

  video_to_axis_packer #(
    .DSIZE      (DSIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .pclk      (pclk),
    .prst      (prst),
    .enable    (enable),
    .hactive   (hactive),
    .vactive   (vactive),
    .vs        (vs),
    .hs        (hs),
    .de        (de),
    .data      (data),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tuser   (m_tuser),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .clear_err (clear_err),
    .overflow  (overflow),
    .line_err  (line_err),
    .frame_err (frame_err)
  );

  // Every accepted beat is recorded as {tuser, tlast, tdata}.
  always @(negedge pclk) begin
    if (!prst && m_tvalid && m_tready) beats.push_back({m_tuser, m_tlast, m_tdata});
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] beat(input logic u, input logic l, input logic [DSIZE-1:0] d);
    return 32'({u, l, d});
  endfunction

  function automatic logic [31:0] got(input int i);
    return (i < beats.size()) ? 32'(beats[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic send_line(input int n, input logic [DSIZE-1:0] base);
    for (int i = 0; i < n; i++) begin
      de   = 1'b1;
      data = base + DSIZE'(i);
      tick();
    end
    de   = 1'b0;
    data = '0;
    repeat (4) tick();
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    tick();
    tick();
    vs = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    prst = 1'b1; enable = 1'b0; vs = 1'b0; hs = 1'b0; de = 1'b0; data = '0;
    m_tready = 1'b1; clear_err = 1'b0; hactive = 16'd8; vactive = 16'd4;
    repeat (3) tick();
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata",  32'(m_tdata),  32'd0);
    check("rst_flags",  32'({m_tuser, m_tlast, overflow, line_err, frame_err}), 32'd0);
    check("rst_state",  32'(dut.state_q), 32'(ST_IDLE));
    prst = 1'b0;
    enable = 1'b1;
    tick();

    // Normal 8x4 frame, with input-to-tvalid latency measured on the first pixel
    beats.delete();
    vs_pulse();
    de = 1'b1; data = 24'h100;
    tick();
    check("lat_1cyc", 32'(m_tvalid), 32'd0);
    data = 24'h101;
    tick();
    check("lat_2cyc", 32'(m_tvalid), 32'd1);
    check("lat_head", 32'({m_tuser, m_tlast, m_tdata}), beat(1'b1, 1'b0, 24'h100));
    for (int i = 2; i < 8; i++) begin
      data = 24'h100 + 24'(i);
      tick();
    end
    de = 1'b0; data = '0;
    repeat (4) tick();
    for (int l = 1; l < 4; l++) send_line(8, 24'h100 + 24'(16 * l));
    repeat (4) tick();
    check("norm_count", 32'(beats.size()), 32'd32);
    for (int i = 0; i < 32; i++)
      check($sformatf("norm_beat%0d", i), got(i),
            beat(i == 0, (i % 8) == 7, 24'h100 + 24'(16 * (i / 8) + i % 8)));
    check("norm_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Backpressure: 10 stalled cycles from the 4th pixel of line 1
    beats.delete();
    vs_pulse();
    send_line(8, 24'h200);
    for (int p = 0; p < 8; p++) begin
      de = 1'b1; data = 24'h210 + 24'(p);
      if (p == 3) m_tready = 1'b0;
      tick();
    end
    de = 1'b0; data = '0;
    repeat (5) tick();
    check("bp_hold", 32'({m_tvalid, m_tuser, m_tlast, m_tdata}), 32'({1'b1, 1'b0, 1'b0, 24'h211}));
    m_tready = 1'b1;
    repeat (2) tick();
    send_line(8, 24'h220);
    send_line(8, 24'h230);
    repeat (12) tick();
    check("bp_ovf", 32'(overflow), 32'd0);
    check("bp_count", 32'(beats.size()), 32'd32);
    for (int i = 0; i < 32; i++)
      check($sformatf("bp_beat%0d", i), got(i),
            beat(i == 0, (i % 8) == 7, 24'h200 + 24'(16 * (i / 8) + i % 8)));

    // Overflow: no ready for the whole frame
    beats.delete();
    m_tready = 1'b0;
    vs_pulse();
    for (int l = 0; l < 4; l++) send_line(8, 24'hB00 + 24'(16 * l));
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_state", 32'(dut.state_q), 32'(ST_DROP));
    check("ovf_none",  32'(beats.size()), 32'd0);
    m_tready = 1'b1;
    repeat (20) tick();
    check("ovf_drain", 32'(beats.size()), 32'd16);
    check("ovf_b0",  got(0),  beat(1'b1, 1'b0, 24'hB00));
    check("ovf_b7",  got(7),  beat(1'b0, 1'b1, 24'hB07));
    check("ovf_b15", got(15), beat(1'b0, 1'b1, 24'hB17));
    send_line(8, 24'hC00);
    repeat (4) tick();
    check("ovf_after", 32'(beats.size()), 32'd16);
    check("ovf_tvalid", 32'(m_tvalid), 32'd0);

    // Short and long lines, hactive=8, vactive=3
    pulse_clear();
    check("clr_ovf", 32'(overflow), 32'd0);
    beats.delete();
    vactive = 16'd3;
    vs_pulse();
    send_line(6, 24'h400);
    check("short_err", 32'(line_err), 32'd1);
    pulse_clear();
    check("short_clr", 32'(line_err), 32'd0);
    send_line(10, 24'h500);
    check("long_err", 32'(line_err), 32'd1);
    send_line(8, 24'h600);
    send_line(8, 24'h700);
    repeat (4) tick();
    check("sl_count", 32'(beats.size()), 32'd30);
    check("short_b0", got(0), beat(1'b1, 1'b0, 24'h400));
    check("short_b5", got(5), beat(1'b0, 1'b0, 24'h405));
    check("long_b13", got(13), beat(1'b0, 1'b1, 24'h507));
    check("long_b14", got(14), beat(1'b0, 1'b0, 24'h600));
    check("sl_b29", got(29), beat(1'b0, 1'b1, 24'h707));
    check("sl_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Early vs after 2 of 4 lines
    beats.delete();
    vactive = 16'd4;
    vs_pulse();
    send_line(8, 24'h800);
    send_line(8, 24'h810);
    check("early_noerr", 32'(frame_err), 32'd0);
    vs_pulse();
    check("early_ferr",  32'(frame_err), 32'd1);
    check("early_state", 32'(dut.state_q), 32'(ST_WAIT_DE));
    send_line(8, 24'h820);
    check("early_count", 32'(beats.size()), 32'd24);
    check("early_sof", got(16), beat(1'b1, 1'b0, 24'h820));
    pulse_clear();
    check("clr_all", 32'({overflow, line_err, frame_err}), 32'd0);

    // Reset mid-frame with 5 beats queued
    beats.delete();
    m_tready = 1'b0;
    vs_pulse();
    send_line(5, 24'h900);
    check("rmf_queued", 32'(m_tvalid), 32'd1);
    prst = 1'b1;
    tick();
    check("rmf_tvalid", 32'(m_tvalid), 32'd0);
    check("rmf_outs",   32'({m_tuser, m_tlast, m_tdata}), 32'd0);
    check("rmf_state",  32'(dut.state_q), 32'(ST_IDLE));
    prst = 1'b0;
    m_tready = 1'b1;
    tick();
    send_line(8, 24'hA00);
    check("rmf_nobeats", 32'(beats.size()), 32'd0);
    enable = 1'b0;
    vs_pulse();
    send_line(8, 24'hA10);
    check("dis_nobeats", 32'(beats.size()), 32'd0);
    check("dis_state", 32'(dut.state_q), 32'(ST_IDLE));
    enable = 1'b1;
    vs_pulse();
    send_line(8, 24'hA20);
    check("resume_count", 32'(beats.size()), 32'd8);
    check("resume_b0", got(0), beat(1'b1, 1'b0, 24'hA20));
    check("resume_b7", got(7), beat(1'b0, 1'b1, 24'hA27));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/video_to_axis_packer.md
VIDEO_TO_AXIS_PACKER -- requirements
Module: video_to_axis_packer

Interface
REQ-001 Parameter DSIZE, default 24, SHALL set the pixel data width (tdata width).
REQ-002 Parameter FIFO_DEPTH, default 16, power of two, SHALL set the output FIFO entry count.
REQ-003 pclk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 prst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 enable  input  1  SHALL enable packing; sampled only at vs rising edge.
REQ-006 hactive  input  16  SHALL give pixels per line; it is sampled at vs rising edge.
REQ-007 vactive  input  16  SHALL give lines per frame; it is sampled at vs rising edge.
REQ-008 vs, hs, de  input  1 each  SHALL carry the pixel-timing syncs, active-high.
REQ-009 data  input  DSIZE  SHALL carry pixel data, valid when de=1.
REQ-010 m_tdata  output  DSIZE  SHALL carry the AXI4-Stream pixel.
REQ-011 m_tvalid, m_tuser, m_tlast  output  1 each  SHALL carry valid, start-of-frame and end-of-line.
REQ-012 m_tready  input  1  SHALL carry downstream ready.
REQ-013 clear_err  input  1  SHALL clear sticky error flags when pulsed.
REQ-014 overflow, line_err, frame_err  output  1 each  SHALL be the sticky error flags.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_DE, ACTIVE and DROP.
REQ-016 IDLE -> WAIT_DE SHALL occur on vs rising edge (vs=1, previous vs=0) with enable=1 and sampled hactive!=0 and vactive!=0; otherwise the FSM SHALL stay in IDLE.
REQ-017 WAIT_DE -> ACTIVE SHALL occur on the first de=1 cycle; that pixel SHALL be written with sof=1.
REQ-018 In ACTIVE, each de=1 pixel SHALL be written with eol=1 when pix_cnt==hactive-1.
  - pix_cnt then returns to 0 and line_cnt increments.
REQ-019 When line_cnt reaches vactive after an eol, the FSM SHALL go to IDLE.
REQ-020 A vs rising edge while in ACTIVE or DROP SHALL restart the frame.
  - The FSM SHALL go to WAIT_DE (or IDLE if enable=0).
  - frame_err SHALL be set if the FSM was in ACTIVE.
REQ-021 In ACTIVE, de falling with pix_cnt!=0 (short line) SHALL set line_err and reset pix_cnt to 0; no tlast is inserted.
REQ-022 A de=1 pixel arriving after eol but before de falls (long line) SHALL be dropped and SHALL set line_err.
REQ-023 A write attempted while the FIFO is full SHALL be discarded, SHALL set overflow, and SHALL move the FSM to DROP.
  - DROP writes nothing until the next vs rising edge.
  - Entries already queued SHALL still drain.
REQ-024 FIFO entries SHALL be {sof, eol, data}, width DSIZE+2, show-ahead.
  - m_tvalid = !empty.
  - A pop occurs on m_tvalid && m_tready.
REQ-025 Latency from a de=1 input sample to m_tvalid (FIFO empty) SHALL be exactly 2 pclk cycles: 1 cycle input register plus 1 cycle FIFO.
REQ-026 A simultaneous push and pop SHALL be legal at any fill level except:
  - When full, the push SHALL be rejected even if a pop occurs in the same cycle (registered full flag).
REQ-027 m_tdata, m_tuser and m_tlast SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-028 clear_err SHALL clear all three flags the cycle after it is sampled.
  - A same-cycle set SHALL win over clear.
REQ-029 pix_cnt and line_cnt SHALL be 16 bits wide, compared unsigned, and SHALL never wrap within a legal frame.

Reset
REQ-030 prst=1 SHALL force:
  - FSM to IDLE;
  - counters, FIFO pointers, error flags and the vs history to 0;
  - m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=0.
REQ-031 Reset asserted mid-frame SHALL flush the FIFO.
  - Packing SHALL resume only at the next vs rising edge after prst deasserts.

Structure
REQ-032 The FSM state enum and FIFO entry typedef SHALL live in SystemPkg.
REQ-033 The FIFO SHALL be a separate sub-module, vid_sync_fifo, parameterised by DSIZE+2 and FIFO_DEPTH, exposing full and empty.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
  - Normal frame: hactive=8, vactive=4, m_tready=1 -> 32 beats; tuser on beat 0 only; tlast on beats 7, 15, 23, 31; FSM IDLE afterwards.
  - Backpressure: same frame with m_tready=0 for 10 cycles mid-line, depth 16 -> no overflow; beat order and data intact; outputs stable while stalled.
  - Overflow: m_tready=0 for the whole frame, hactive=8, vactive=4 -> 16 beats queued, overflow=1, FSM DROP; after m_tready=1, exactly 16 beats drain, then none until the next vs.
  - Short and long lines: line of 6 pixels with hactive=8 -> line_err=1, no tlast on those beats; line of 10 pixels -> 8 beats (tlast on the 8th), 2 dropped, line_err=1.
  - Early vs: vs rising after 2 of 4 lines -> frame_err=1; the next frame's first beat has tuser=1; clear_err -> all flags 0 the next cycle.
  - Reset mid-frame: prst pulse after 5 beats queued -> m_tvalid=0 the next cycle; no beats until the following vs rising edge; enable=0 at vs -> no beats.
